picomips_ctrl: RTL



---
 rtl/picomips_pkg.sv | 22 ++
 rtl/picomips_ctrl_btn_sync.sv | 26 ++
 rtl/picomips_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// picomips_pkg: definitions shared by the picoMips controller and its ALU.
//   OP_*    : 3-bit opcodes carried in Instr[15:13], driven onto the ALU Func port
//   state_e : sequencer states
package picomips_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_MULI = 3'd3;
  localparam logic [2:0] OP_RTA  = 3'd4;
  localparam logic [2:0] OP_LSW  = 3'd5;
  localparam logic [2:0] OP_ATR  = 3'd6;
  localparam logic [2:0] OP_WSW  = 3'd7;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE
  } state_e;

endpackage

// File: rtl/picomips_ctrl_btn_sync.sv
// btn_sync: STAGES-deep flop chain that brings an asynchronous level into
// the clock domain. Only the last flop is visible, so a metastable first
// stage gets a full cycle to resolve.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the chain
//   d_i    : raw asynchronous input
//   q_o    : synchronised level
module btn_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/picomips_ctrl.sv
// picomips_ctrl: picoMips sequencer and decoder.
//   Clock, nReset : clock (rising edge), asynchronous active-low reset
//   Instr         : ROM word at address PC (combinational)
//   Button        : raw asynchronous push button
//   PC            : program counter / ROM address
//   Func, WE, SelSW, SelImm, Imm : ALU controls
//   RegAddr, RegWE: register file controls (write data is the ALU accumulator)
//   Waiting       : high while stalled in the WSW button handshake
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int PC_W        = 5,
  parameter int RA_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [15:0]     Instr,
  input  logic            Button,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      Func,
  output logic            WE,
  output logic            SelSW,
  output logic            SelImm,
  output logic [7:0]      Imm,
  output logic [RA_W-1:0] RegAddr,
  output logic            RegWE,
  output logic            Waiting
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            btn_s;
  logic [2:0]      op;
  logic [PC_W-1:0] tgt;

  assign op  = Instr[15:13];
  // Branch target is field F; narrower PC truncates, wider PC zero-extends.
  assign tgt = PC_W'(Instr[12:8]);

  btn_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clk_i  (Clock),
    .rst_ni (nReset),
    .d_i    (Button),
    .q_o    (btn_s)
  );

  // While waiting, PC is held on the WSW word, so Instr still carries
  // its branch target when the release is seen.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN: begin
          if (op == OP_WSW) state_q <= ST_WAIT_PRESS;
          else              pc_q    <= pc_q + PC_W'(1);
        end
        ST_WAIT_PRESS: if (btn_s) state_q <= ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: begin
          if (!btn_s) begin
            pc_q    <= tgt;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign PC      = pc_q;
  assign Waiting = (state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE);

  // All decode outputs are gated by RUN so reset/boot/wait drive nothing.
  always_comb begin
    Func    = '0;
    WE      = 1'b0;
    SelSW   = 1'b0;
    SelImm  = 1'b0;
    Imm     = '0;
    RegAddr = '0;
    RegWE   = 1'b0;
    if (state_q == ST_RUN) begin
      Func    = op;
      Imm     = Instr[7:0];
      RegAddr = Instr[8 +: RA_W];
      unique case (op)
        OP_ADD, OP_RTA:  WE = 1'b1;
        OP_ADDI, OP_MULI: begin
          WE     = 1'b1;
          SelImm = 1'b1;
        end
        OP_LSW: begin
          WE    = 1'b1;
          SelSW = 1'b1;
        end
        OP_ATR:  RegWE = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
